// File: rtl/fetch_redirect_unit_pkg.sv
// Shared widths, FSM encodings and next-PC select codes for the fetch redirect logic.
package fetch_redirect_unit_pkg;

   localparam int unsigned PC_W      = 32;
   localparam int unsigned INSTR_W   = 16;
   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } fetch_state_t;

   typedef enum logic [2:0] {
      BRANCH  = 3'd0,
      HOLD    = 3'd1,
      HELDJMP = 3'd2,
      JMP     = 3'd3,
      SEQ     = 3'd4
   } next_pc_sel_t;

endpackage

// File: rtl/fetch_next_pc_mux.sv
// Combinational priority select of next PC and IF/ID bubble control; zero latency.
// A stall selects HOLD so the parent freezes PC and IF/ID; only a taken branch overrides it.
module fetch_next_pc_mux
   import fetch_redirect_unit_pkg::*;
#(
   parameter int unsigned PC_W = 32
) (
   input  logic            held,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] held_target,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            stall_out,
   input  logic            take_jmp,
   input  logic            stall_jump,
   input  logic            jmp_uncond,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            nop,
   output next_pc_sel_t    sel,
   output logic [PC_W-1:0] next_pc,
   output logic            if_id_bubble
);

   always_comb begin
      sel          = SEQ;
      next_pc      = pc + PC_W'(1);
      if_id_bubble = 1'b0;
      if (br_taken) begin
         sel          = BRANCH;
         next_pc      = br_target;
         if_id_bubble = 1'b1;
      end else if (stall_out) begin
         sel     = HOLD;
         next_pc = pc;
      end else if (take_jmp && held) begin
         sel          = HELDJMP;
         next_pc      = held_target;
         if_id_bubble = 1'b1;
      end else if (jmp_uncond && !stall_jump && !held) begin
         sel          = JMP;
         next_pc      = jmp_target;
         if_id_bubble = 1'b1;
      end else if (nop) begin
         if_id_bubble = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC, deferred-jump FSM and IF/ID register; redirects appear on pc one cycle after the request.
// stall_out freezes pc and IF/ID while still allowing a jump target to be captured.
module fetch_redirect_unit #(
   parameter int unsigned         PC_W      = fetch_redirect_unit_pkg::PC_W,
   parameter int unsigned         INSTR_W   = fetch_redirect_unit_pkg::INSTR_W,
   parameter logic [PC_W-1:0]     RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_out,
   input  logic               take_jmp,
   input  logic               stall_jump,
   input  logic               nop,
   input  logic               jmp_uncond,
   input  logic [PC_W-1:0]    jmp_target,
   input  logic               br_taken,
   input  logic [PC_W-1:0]    br_target,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [PC_W-1:0]    if_id_pc,
   output logic               if_id_valid,
   output logic               held_valid
);
   import fetch_redirect_unit_pkg::*;

   fetch_state_t    state_q, state_nxt;
   logic [PC_W-1:0] held_target_q, held_target_nxt;
   next_pc_sel_t    sel;
   logic [PC_W-1:0] next_pc;
   logic            if_id_bubble;

   assign held_valid = (state_q == HELD);

   fetch_next_pc_mux #(.PC_W(PC_W)) u_mux (
      .held         (held_valid),
      .pc           (pc),
      .held_target  (held_target_q),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .stall_out    (stall_out),
      .take_jmp     (take_jmp),
      .stall_jump   (stall_jump),
      .jmp_uncond   (jmp_uncond),
      .jmp_target   (jmp_target),
      .nop          (nop),
      .sel          (sel),
      .next_pc      (next_pc),
      .if_id_bubble (if_id_bubble)
   );

   // A taken branch squashes any pending jump, including one being captured this cycle.
   always_comb begin
      state_nxt       = state_q;
      held_target_nxt = held_target_q;
      if (br_taken) begin
         state_nxt       = IDLE;
         held_target_nxt = '0;
      end else if (state_q == IDLE) begin
         if (stall_out && jmp_uncond && !stall_jump) begin
            state_nxt       = HELD;
            held_target_nxt = jmp_target;
         end
      end else if (take_jmp && !stall_out) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         held_target_q <= '0;
      end else begin
         state_q       <= state_nxt;
         held_target_q <= held_target_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc          <= RESET_PC;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else if (sel != HOLD) begin
         pc <= next_pc;
         if (if_id_bubble) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else begin
            if_id_instr <= imem_instr;
            if_id_pc    <= next_pc;
            if_id_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed checks of fetch_redirect_unit: reset, sequential fetch, jumps, stalls, branch priority, wrap.
module tb_fetch_redirect_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_out, take_jmp, stall_jump, nop, jmp_uncond, br_taken;
   logic [31:0] jmp_target, br_target;
   logic [15:0] imem_instr;
   logic [31:0] pc, if_id_pc;
   logic [15:0] if_id_instr;
   logic        if_id_valid, held_valid;

   logic        rst_w;
   logic        zero_b = 1'b0;
   logic [7:0]  zero_8 = 8'h00;
   logic [15:0] imem_w = 16'hC0DE;
   logic [7:0]  w_pc, w_if_id_pc;
   logic [15:0] w_if_id_instr;
   logic        w_if_id_valid, w_held_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_redirect_unit dut (
      .clk(clk), .rst(rst), .stall_out(stall_out), .take_jmp(take_jmp),
      .stall_jump(stall_jump), .nop(nop), .jmp_uncond(jmp_uncond),
      .jmp_target(jmp_target), .br_taken(br_taken), .br_target(br_target),
      .imem_instr(imem_instr), .pc(pc), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .held_valid(held_valid)
   );

   fetch_redirect_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) dut_w (
      .clk(clk), .rst(rst_w), .stall_out(zero_b), .take_jmp(zero_b),
      .stall_jump(zero_b), .nop(zero_b), .jmp_uncond(zero_b),
      .jmp_target(zero_8), .br_taken(zero_b), .br_target(zero_8),
      .imem_instr(imem_w), .pc(w_pc), .if_id_instr(w_if_id_instr),
      .if_id_pc(w_if_id_pc), .if_id_valid(w_if_id_valid), .held_valid(w_held_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall_out = 0; take_jmp = 0; stall_jump = 0; nop = 0;
      jmp_uncond = 0; br_taken = 0; jmp_target = 0; br_target = 0;
      imem_instr = 16'hFFFF;
   endtask

   task automatic test_reset();
      rst = 0; rst_w = 0; clear_inputs();
      tick(); tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      checks++; if (if_id_instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 16'h0); end
      checks++; if (if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_if_id_pc: got %h want %h", if_id_pc, 32'h0); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", held_valid); end
      checks++; if (w_pc !== 8'hFE) begin errors++; $display("FAIL reset_pc_param: got %h want fe", w_pc); end
      rst = 1;
   endtask

   task automatic test_seq_fetch();
      clear_inputs(); jmp_uncond = 1; jmp_target = 32'h5;
      tick();
      checks++; if (pc !== 32'h5) begin errors++; $display("FAIL seq_setup_pc: got %h want %h", pc, 32'h5); end
      clear_inputs(); imem_instr = 16'h1234;
      tick();
      checks++; if (pc !== 32'h6) begin errors++; $display("FAIL seq_pc: got %h want %h", pc, 32'h6); end
      checks++; if (if_id_instr !== 16'h1234) begin errors++; $display("FAIL seq_instr: got %h want 1234", if_id_instr); end
      checks++; if (if_id_pc !== 32'h6) begin errors++; $display("FAIL seq_if_id_pc: got %h want %h", if_id_pc, 32'h6); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b want 1", if_id_valid); end
   endtask

   task automatic test_direct_jump();
      clear_inputs(); jmp_uncond = 1; jmp_target = 32'h20; imem_instr = 16'hAAAA;
      tick();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL jmp_pc: got %h want %h", pc, 32'h20); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jmp_bubble_valid: got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== 16'h0) begin errors++; $display("FAIL jmp_bubble_instr: got %h want 0000", if_id_instr); end
      checks++; if (if_id_pc !== 32'h6) begin errors++; $display("FAIL jmp_bubble_pc_kept: got %h want %h", if_id_pc, 32'h6); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL jmp_no_held: got %b want 0", held_valid); end
   endtask

   task automatic test_load_use_jump();
      clear_inputs(); stall_out = 1; jmp_uncond = 1; jmp_target = 32'h80; imem_instr = 16'h7777;
      tick();
      checks++; if (pc !== 32'h20) begin errors++; $display("FAIL lu_stall_pc: got %h want %h", pc, 32'h20); end
      checks++; if (held_valid !== 1'b1) begin errors++; $display("FAIL lu_held: got %b want 1", held_valid); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL lu_stall_valid: got %b want 0", if_id_valid); end
      clear_inputs(); take_jmp = 1; nop = 1; stall_jump = 1; jmp_uncond = 1; jmp_target = 32'h80;
      tick();
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL lu_take_pc: got %h want %h", pc, 32'h80); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL lu_take_bubble: got %b want 0", if_id_valid); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL lu_take_held: got %b want 0", held_valid); end
      clear_inputs(); stall_jump = 1; jmp_uncond = 1; jmp_target = 32'h80; imem_instr = 16'hBEEF;
      tick();
      checks++; if (pc !== 32'h81) begin errors++; $display("FAIL lu_no_retake_pc: got %h want %h", pc, 32'h81); end
      checks++; if (if_id_instr !== 16'hBEEF) begin errors++; $display("FAIL lu_no_retake_instr: got %h want beef", if_id_instr); end
      checks++; if (if_id_pc !== 32'h81) begin errors++; $display("FAIL lu_no_retake_if_id_pc: got %h want %h", if_id_pc, 32'h81); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL lu_no_retake_valid: got %b want 1", if_id_valid); end
   endtask

   task automatic test_stall_over_take();
      clear_inputs(); stall_out = 1; jmp_uncond = 1; jmp_target = 32'h30;
      tick();
      clear_inputs(); stall_out = 1; take_jmp = 1;
      tick();
      checks++; if (pc !== 32'h81) begin errors++; $display("FAIL stall_take_pc: got %h want %h", pc, 32'h81); end
      checks++; if (held_valid !== 1'b1) begin errors++; $display("FAIL stall_take_held: got %b want 1", held_valid); end
      clear_inputs(); take_jmp = 1;
      tick();
      checks++; if (pc !== 32'h30) begin errors++; $display("FAIL stall_then_take_pc: got %h want %h", pc, 32'h30); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL stall_then_take_held: got %b want 0", held_valid); end
   endtask

   task automatic test_branch_priority();
      clear_inputs(); stall_out = 1; jmp_uncond = 1; jmp_target = 32'h80;
      tick();
      checks++; if (held_valid !== 1'b1) begin errors++; $display("FAIL br_setup_held: got %b want 1", held_valid); end
      clear_inputs(); take_jmp = 1; br_taken = 1; br_target = 32'h10;
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_pc: got %h want %h", pc, 32'h10); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL br_held: got %b want 0", held_valid); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %b want 0", if_id_valid); end
      clear_inputs(); take_jmp = 1; imem_instr = 16'h5A5A;
      tick();
      checks++; if (pc !== 32'h11) begin errors++; $display("FAIL idle_take_pc: got %h want %h", pc, 32'h11); end
      checks++; if (if_id_instr !== 16'h5A5A) begin errors++; $display("FAIL idle_take_instr: got %h want 5a5a", if_id_instr); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL idle_take_valid: got %b want 1", if_id_valid); end
   endtask

   task automatic test_nop();
      clear_inputs(); nop = 1; jmp_uncond = 1; jmp_target = 32'h70;
      tick();
      checks++; if (pc !== 32'h70) begin errors++; $display("FAIL nop_jmp_pc: got %h want %h", pc, 32'h70); end
      clear_inputs(); nop = 1; imem_instr = 16'h4321;
      tick();
      checks++; if (pc !== 32'h71) begin errors++; $display("FAIL nop_pc: got %h want %h", pc, 32'h71); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL nop_valid: got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== 16'h0) begin errors++; $display("FAIL nop_instr: got %h want 0000", if_id_instr); end
      checks++; if (if_id_pc !== 32'h11) begin errors++; $display("FAIL nop_if_id_pc_kept: got %h want %h", if_id_pc, 32'h11); end
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs(); jmp_uncond = 1; jmp_target = 32'h40;
      tick();
      clear_inputs(); stall_out = 1; jmp_uncond = 1; jmp_target = 32'h99;
      tick();
      checks++; if (pc !== 32'h40 || held_valid !== 1'b1) begin errors++; $display("FAIL rst_setup: got pc %h held %b want pc 40 held 1", pc, held_valid); end
      rst = 0;
      #1;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_mid_pc: got %h want %h", pc, 32'h0); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", if_id_valid); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_held: got %b want 0", held_valid); end
      tick();
      rst = 1; clear_inputs(); take_jmp = 1;
      tick();
      checks++; if (pc !== 32'h1) begin errors++; $display("FAIL rst_discard_pc: got %h want %h", pc, 32'h1); end
      checks++; if (held_valid !== 1'b0) begin errors++; $display("FAIL rst_discard_held: got %b want 0", held_valid); end
   endtask

   task automatic test_wrap();
      rst_w = 1;
      tick();
      checks++; if (w_pc !== 8'hFF) begin errors++; $display("FAIL wrap_pre_pc: got %h want ff", w_pc); end
      tick();
      checks++; if (w_pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h want 00", w_pc); end
      checks++; if (w_if_id_pc !== 8'h00) begin errors++; $display("FAIL wrap_if_id_pc: got %h want 00", w_if_id_pc); end
      checks++; if (w_if_id_valid !== 1'b1 || w_if_id_instr !== 16'hC0DE) begin errors++; $display("FAIL wrap_if_id: got valid %b instr %h want 1 c0de", w_if_id_valid, w_if_id_instr); end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_direct_jump();
      test_load_use_jump();
      test_stall_over_take();
      test_branch_priority();
      test_nop();
      test_reset_mid_stall();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side PC and IF/ID register control.
- Sits directly downstream of the load-use/unconditional-jump stall controller and consumes its stall_out, take_jmp, stall_jump and nop outputs.
- Owns the PC, holds a deferred jump target across a load-use stall, and decides per cycle between hold, redirect, bubble and sequential fetch.
- Drives the instruction-memory address and the IF/ID pipeline register.

Parameters:
- PC_W, 32, PC / address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 0, encoding written into IF/ID for a bubble.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_out  in  1  load-use stall from controller; freeze PC and IF/ID.
- take_jmp  in  1  controller: apply held jump target this cycle.
- stall_jump  in  1  controller: jump in ID already serviced; do not re-take it.
- nop  in  1  controller: load bubble into IF/ID.
- jmp_uncond  in  1  decode: unconditional jump in ID.
- jmp_target  in  PC_W  decode: jump target of ID instruction.
- br_taken  in  1  EX: conditional branch resolved taken.
- br_target  in  PC_W  EX: branch target.
- imem_instr  in  INSTR_W  instruction read at pc.
- pc  out  PC_W  current fetch address.
- if_id_instr  out  INSTR_W  IF/ID instruction.
- if_id_pc  out  PC_W  IF/ID PC (PC of that instruction + 1).
- if_id_valid  out  1  0 = bubble.
- held_valid  out  1  a deferred jump target is pending (debug/verification).

Behaviour:
- Reset (rst low, asynchronous):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - held_valid=0, held target=0, FSM=IDLE.
  - Reset mid-stall discards any held target.
- FSM, two states:
  - IDLE → HELD when stall_out=1 and jmp_uncond=1 and stall_jump=0; capture jmp_target into the held register.
  - HELD → IDLE on the cycle take_jmp=1, or when br_taken=1 (branch squashes the pending jump).
  - take_jmp in IDLE is ignored: pc advances per the priority list below.
- Per-cycle PC update, priority high to low:
  1. br_taken: pc←br_target; IF/ID←bubble; held cleared.
  2. stall_out: pc and IF/ID hold their values. Capturing the held target is still allowed.
  3. take_jmp and HELD: pc←held target; IF/ID←bubble.
  4. jmp_uncond and !stall_jump and IDLE: pc←jmp_target; IF/ID←bubble (single-cycle redirect, no stall).
  5. nop: pc←pc+1; IF/ID←bubble.
  6. Otherwise: pc←pc+1; IF/ID←{imem_instr, pc+1, valid=1}.
- Bubble: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc unchanged.
- Latency: a redirect is visible on pc one cycle after the qualifying input. The first valid instruction from the new target enters IF/ID on the following cycle.
- pc+1 wraps modulo 2^PC_W with no flag.
- Simultaneous events:
  - stall_out with take_jmp: stall wins and HELD persists.
  - nop with a redirect: the redirect wins, since a redirect already bubbles.
  - stall_jump=1 suppresses rule 4 only.
- held_valid is 1 exactly in HELD.

Decomposition:
- Shared package holds:
  - PC_W, INSTR_W, NOP_INSTR constants.
  - FSM state encodings IDLE=1'b0, HELD=1'b1.
  - The next-PC select enum: BRANCH, HOLD, HELDJMP, JMP, SEQ.
- One natural sub-module, fetch_next_pc_mux: purely combinational priority select producing next pc and IF/ID load/bubble controls.
- The parent holds the registers and the FSM.

Test Plan:
- Reset: rst low mid-run with pc=0x40 and HELD → immediately pc=0, if_id_valid=0, held_valid=0.
- Sequential fetch: no controls, imem_instr=0x1234 at pc=5 → next cycle pc=6, if_id_instr=0x1234, if_id_pc=6, valid=1.
- Load-use jump:
  - cycle 0: stall_out=1, jmp_uncond=1, jmp_target=0x80 → pc held, held_valid=1.
  - cycle 1: take_jmp=1, nop=1 → pc=0x80, bubble.
  - cycle 2: stall_jump=1, jmp_uncond=1 → pc=0x81, jump not re-taken.
- Direct jump: jmp_uncond=1, jmp_target=0x20, no stall → pc=0x20 next cycle, IF/ID bubble.
- Branch priority: HELD with target 0x80, then br_taken=1, br_target=0x10 in the same cycle as take_jmp → pc=0x10, held_valid=0.
- Wrap: PC_W=8, pc=0xFF, no controls → pc=0x00.
